// File: rtl/alu_mc.sv
// Multi-cycle ALU: registered single-cycle logic/arith/shift ops plus iterative
// shift-add unsigned multiply and restoring unsigned divide, behind valid/ready handshakes.
module alu_mc #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [4:0]   i_funct,
    input  logic [W-1:0] i_data1,
    input  logic [W-1:0] i_data2,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_result,
    output logic [W-1:0] o_result_hi,
    output logic         o_zero,
    output logic         o_carry,
    output logic         o_overflow,
    output logic         o_divz,
    output logic         o_err,
    output logic [1:0]   o_dbg_state
);

    // Handshake: a request transfers on a rising edge where i_valid && o_ready;
    // a response transfers on a rising edge where o_valid && i_ready.

    localparam int SW = $clog2(W);
    localparam logic [SW:0] CNT_LAST = (SW+1)'(W-1);

    localparam logic [4:0] F_AND  = 5'b00000;
    localparam logic [4:0] F_OR   = 5'b00001;
    localparam logic [4:0] F_ADD  = 5'b00010;
    localparam logic [4:0] F_NOR  = 5'b00011;
    localparam logic [4:0] F_SLL  = 5'b00101;
    localparam logic [4:0] F_SUB  = 5'b00110;
    localparam logic [4:0] F_SLT  = 5'b00111;
    localparam logic [4:0] F_SRA  = 5'b01000;
    localparam logic [4:0] F_SRL  = 5'b01001;
    localparam logic [4:0] F_XOR  = 5'b01011;
    localparam logic [4:0] F_MULU = 5'b01100;
    localparam logic [4:0] F_DIVU = 5'b01101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] opnd_q, opnd_d;
    logic [W-1:0] acc_hi_q, acc_hi_d;
    logic [W-1:0] acc_lo_q, acc_lo_d;
    logic [SW:0]  cnt_q, cnt_d;
    logic [W-1:0] res_q, res_d;
    logic [W-1:0] res_hi_q, res_hi_d;
    logic         zero_q, zero_d;
    logic         carry_q, carry_d;
    logic         ovf_q, ovf_d;
    logic         divz_q, divz_d;
    logic         err_q, err_d;
    logic         valid_q, valid_d;

    logic [W:0]    sum, dif;
    logic          sub_v;
    logic [SW-1:0] shamt;
    logic [W-1:0]  sc_res;
    logic          sc_c, sc_v, sc_err;

    always_comb begin
        shamt  = i_data2[SW-1:0];
        sum    = {1'b0, i_data1} + {1'b0, i_data2};
        dif    = {1'b0, i_data1} - {1'b0, i_data2};
        sub_v  = (i_data1[W-1] != i_data2[W-1]) && (dif[W-1] != i_data1[W-1]);
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_err = 1'b0;
        case (i_funct)
            F_AND: sc_res = i_data1 & i_data2;
            F_OR:  sc_res = i_data1 | i_data2;
            F_ADD: begin
                sc_res = sum[W-1:0];
                sc_c   = sum[W];
                sc_v   = (i_data1[W-1] == i_data2[W-1]) && (sum[W-1] != i_data1[W-1]);
            end
            F_NOR: sc_res = ~(i_data1 | i_data2);
            F_SLL: sc_res = i_data1 << shamt;
            F_SUB: begin
                sc_res = dif[W-1:0];
                sc_c   = dif[W];
                sc_v   = sub_v;
            end
            // Signed less-than is the sign of A-B corrected by overflow.
            F_SLT: begin
                sc_res = {{(W-1){1'b0}}, dif[W-1] ^ sub_v};
                sc_c   = dif[W];
                sc_v   = sub_v;
            end
            F_SRA: sc_res = $signed(i_data1) >>> shamt;
            F_SRL: sc_res = i_data1 >> shamt;
            F_XOR: sc_res = i_data1 ^ i_data2;
            F_MULU, F_DIVU: sc_res = '0;
            default: sc_err = 1'b1;
        endcase
    end

    // One iteration step of each multi-cycle algorithm, from the working registers.
    logic [W:0]   mul_sum;
    logic [W-1:0] mul_hi_n, mul_lo_n;
    logic [W:0]   div_sh;
    logic [W-1:0] div_sub;
    logic         div_ge;
    logic [W-1:0] div_rem_n, div_quo_n;

    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_hi_n  = mul_sum[W:1];
        mul_lo_n  = {mul_sum[0], acc_lo_q[W-1:1]};
        div_sh    = {acc_hi_q, acc_lo_q[W-1]};
        div_sub   = div_sh[W-1:0] - opnd_q;
        div_ge    = div_sh >= {1'b0, opnd_q};
        div_rem_n = div_ge ? div_sub : div_sh[W-1:0];
        div_quo_n = {acc_lo_q[W-2:0], div_ge};
    end

    always_comb begin
        state_d  = state_q;
        opnd_d   = opnd_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        divz_d   = divz_q;
        err_d    = err_q;
        valid_d  = valid_q;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    divz_d  = 1'b0;
                    err_d   = 1'b0;
                    case (i_funct)
                        F_MULU: begin
                            state_d  = S_MUL;
                            opnd_d   = i_data1;
                            acc_hi_d = '0;
                            acc_lo_d = i_data2;
                            cnt_d    = '0;
                        end
                        F_DIVU: begin
                            if (i_data2 == '0) begin
                                state_d  = S_DONE;
                                valid_d  = 1'b1;
                                res_d    = '1;
                                res_hi_d = i_data1;
                                zero_d   = 1'b0;
                                divz_d   = 1'b1;
                            end else begin
                                state_d  = S_DIV;
                                opnd_d   = i_data2;
                                acc_hi_d = '0;
                                acc_lo_d = i_data1;
                                cnt_d    = '0;
                            end
                        end
                        default: begin
                            state_d  = S_DONE;
                            valid_d  = 1'b1;
                            res_d    = sc_res;
                            res_hi_d = '0;
                            zero_d   = (sc_res == '0);
                            carry_d  = sc_c;
                            ovf_d    = sc_v;
                            err_d    = sc_err;
                        end
                    endcase
                end
            end
            S_MUL: begin
                acc_hi_d = mul_hi_n;
                acc_lo_d = mul_lo_n;
                cnt_d    = cnt_q + (SW+1)'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_DONE;
                    valid_d  = 1'b1;
                    res_d    = mul_lo_n;
                    res_hi_d = mul_hi_n;
                    zero_d   = (mul_lo_n == '0);
                end
            end
            S_DIV: begin
                acc_hi_d = div_rem_n;
                acc_lo_d = div_quo_n;
                cnt_d    = cnt_q + (SW+1)'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d  = S_DONE;
                    valid_d  = 1'b1;
                    res_d    = div_quo_n;
                    res_hi_d = div_rem_n;
                    zero_d   = (div_quo_n == '0);
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            res_hi_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            divz_q   <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            opnd_q   <= opnd_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            divz_q   <= divz_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
        end
    end

    assign o_ready     = (state_q == S_IDLE);
    assign o_valid     = valid_q;
    assign o_result    = res_q;
    assign o_result_hi = res_hi_q;
    assign o_zero      = zero_q;
    assign o_carry     = carry_q;
    assign o_overflow  = ovf_q;
    assign o_divz      = divz_q;
    assign o_err       = err_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed vector table, multi-cycle corner sequences and
// randomized operations checked against an arithmetic reference model.
module tb_alu_mc;

    localparam int W = 32;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_valid;
    logic         o_ready;
    logic [4:0]   i_funct;
    logic [W-1:0] i_data1, i_data2;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_result, o_result_hi;
    logic         o_zero, o_carry, o_overflow, o_divz, o_err;
    logic [1:0]   dbg_state;
    logic [69:0]  dut_pack;

    alu_mc #(.W(W)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_funct(i_funct), .i_data1(i_data1), .i_data2(i_data2), .o_valid(o_valid),
        .i_ready(i_ready), .o_result(o_result), .o_result_hi(o_result_hi),
        .o_zero(o_zero), .o_carry(o_carry), .o_overflow(o_overflow),
        .o_divz(o_divz), .o_err(o_err), .o_dbg_state(dbg_state)
    );

    assign dut_pack = {o_result_hi, o_result, o_zero, o_carry, o_overflow, o_divz, o_err};

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_bad = 0;
    logic [69:0] exp_q[$];

    typedef struct {
        string       name;
        logic [4:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [4:0]  flags;  // {zero, carry, overflow, divz, err}
        int          lat;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model straight from the arithmetic definitions.
    function automatic logic [69:0] model(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua, ub, p;
        longint sa, sb, s;
        logic [31:0] r, hi;
        logic c, v, dz, er;
        int sh;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        sh = int'(b[4:0]);
        r = 0; hi = 0; c = 0; v = 0; dz = 0; er = 0;
        case (f)
            5'b00000: r = a & b;
            5'b00001: r = a | b;
            5'b00010: begin
                p = ua + ub; r = p[31:0]; c = p[32];
                s = sa + sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            5'b00011: r = ~(a | b);
            5'b00101: r = a << sh;
            5'b00110, 5'b00111: begin
                c = (ua < ub);
                s = sa - sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                r = (f == 5'b00110) ? (a - b) : ((sa < sb) ? 32'd1 : 32'd0);
            end
            5'b01000: r = $signed(a) >>> sh;
            5'b01001: r = a >> sh;
            5'b01011: r = a ^ b;
            5'b01100: begin p = ua * ub; r = p[31:0]; hi = p[63:32]; end
            5'b01101: begin
                if (b == 0) begin r = 32'hFFFFFFFF; hi = a; dz = 1; end
                else begin r = a / b; hi = a % b; end
            end
            default: er = 1;
        endcase
        return {hi, r, (r == 0), c, v, dz, er};
    endfunction

    function automatic int model_lat(input logic [4:0] f, input logic [31:0] b);
        if (f == 5'b01100 || (f == 5'b01101 && b != 0)) return W + 1;
        return 1;
    endfunction

    // Entered at a falling edge with the DUT idle; leaves at a falling edge after the response.
    task automatic run_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input int pulse_at,
                          output logic [69:0] got, output int lat, output int rdy_busy, output int unstable);
        i_funct = f; i_data1 = a; i_data2 = b; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_data1 = $urandom; i_data2 = $urandom; i_funct = 5'b00010;
        lat = 1; rdy_busy = 0; unstable = 0;
        @(negedge i_clk);
        while (!o_valid && lat < 200) begin
            if (o_ready) rdy_busy++;
            i_valid = (lat == pulse_at);
            @(negedge i_clk);
            lat++;
        end
        i_valid = 1'b0;
        got = dut_pack;
        for (int k = 0; k < hold; k++) begin
            @(negedge i_clk);
            if (dut_pack !== got || !o_valid) unstable++;
        end
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic apply(input string name, input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [69:0] exp, input int exp_lat, input int hold, input int pulse_at);
        logic [69:0] got, e;
        int lat, rb, un;
        exp_q.push_back(exp);
        run_op(f, a, b, hold, pulse_at, got, lat, rb, un);
        e = exp_q.pop_front();
        check({name, "_result"}, got, e);
        check({name, "_latency"}, 70'(lat), 70'(exp_lat));
        if (exp_lat > 1) check({name, "_ready_busy"}, 70'(rb), 70'd0);
        if (hold > 0) check({name, "_hold"}, 70'(un), 70'd0);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($urandom_range(0, 15));
            2: begin
                case ($urandom_range(0, 3))
                    0: return 32'hFFFFFFFF;
                    1: return 32'h80000000;
                    2: return 32'h7FFFFFFF;
                    default: return 32'h00000001;
                endcase
            end
            default: return $urandom >> $urandom_range(0, 31);
        endcase
    endfunction

    initial begin
        logic [4:0]  ops[14];
        logic [4:0]  f;
        logic [31:0] a, b;
        int          seen;

        ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00101, 5'b00110, 5'b00111,
                5'b01000, 5'b01001, 5'b01011, 5'b01100, 5'b01101, 5'b01110, 5'b11111};

        tbl[0]  = '{"add_ovf",    5'b00010, 32'h7FFFFFFF, 32'h00000001, 32'h0, 32'h80000000, 5'b00100, 1};
        tbl[1]  = '{"add_carry",  5'b00010, 32'hFFFFFFFF, 32'h00000001, 32'h0, 32'h00000000, 5'b11000, 1};
        tbl[2]  = '{"sub_borrow", 5'b00110, 32'h00000003, 32'h00000005, 32'h0, 32'hFFFFFFFE, 5'b01000, 1};
        tbl[3]  = '{"slt_neg",    5'b00111, 32'hFFFFFFFF, 32'h00000001, 32'h0, 32'h00000001, 5'b00000, 1};
        tbl[4]  = '{"sra",        5'b01000, 32'h80000000, 32'h00000024, 32'h0, 32'hF8000000, 5'b00000, 1};
        tbl[5]  = '{"mulu_max",   5'b01100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5'b00000, 33};
        tbl[6]  = '{"divu",       5'b01101, 32'd100,      32'd7,        32'd2, 32'd14, 5'b00000, 33};
        tbl[7]  = '{"divu_zero",  5'b01101, 32'd5,        32'd0,        32'd5, 32'hFFFFFFFF, 5'b00010, 1};
        tbl[8]  = '{"undef",      5'b01110, 32'h00001234, 32'h00005678, 32'h0, 32'h0, 5'b10001, 1};
        tbl[9]  = '{"nor",        5'b00011, 32'h0,        32'h0,        32'h0, 32'hFFFFFFFF, 5'b00000, 1};
        tbl[10] = '{"sll",        5'b00101, 32'h00000001, 32'h0000001F, 32'h0, 32'h80000000, 5'b00000, 1};
        tbl[11] = '{"srl",        5'b01001, 32'h80000000, 32'h0000003F, 32'h0, 32'h00000001, 5'b00000, 1};
        tbl[12] = '{"xor",        5'b01011, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0, 32'h0F0FF0F0, 5'b00000, 1};
        tbl[13] = '{"sub_ovf",    5'b00110, 32'h80000000, 32'h00000001, 32'h0, 32'h7FFFFFFF, 5'b00100, 1};
        tbl[14] = '{"divu_small", 5'b01101, 32'd7,        32'd100,      32'd7, 32'd0, 5'b10000, 33};
        tbl[15] = '{"and",        5'b00000, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0, 32'h0F000F00, 5'b00000, 1};

        // Reset with a request held: nothing may be accepted.
        i_rst_n = 1'b0; i_ready = 1'b0;
        i_valid = 1'b1; i_funct = 5'b00010; i_data1 = 32'd1; i_data2 = 32'd1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("reset_outputs", dut_pack, 70'd0);
        check("reset_handshake", 70'({o_valid, o_ready}), 70'b01);
        i_valid = 1'b0;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("post_reset_idle", 70'({o_valid, o_ready}), 70'b01);

        for (int i = 0; i < 16; i++)
            apply(tbl[i].name, tbl[i].f, tbl[i].a, tbl[i].b,
                  {tbl[i].hi, tbl[i].lo, tbl[i].flags}, tbl[i].lat, 0, -1);

        // Response held back for 10 cycles, single-cycle and iterative.
        apply("add_hold10", 5'b00010, 32'h7FFFFFFF, 32'h1, {32'h0, 32'h80000000, 5'b00100}, 1, 10, -1);
        apply("mulu_hold10", 5'b01100, 32'h12345678, 32'h9ABCDEF0,
              model(5'b01100, 32'h12345678, 32'h9ABCDEF0), W + 1, 10, -1);

        // A request pulsed mid-multiply must be ignored, with no extra response afterwards.
        apply("mulu_pulse", 5'b01100, 32'd300, 32'd7, {32'h0, 32'd2100, 5'b00000}, W + 1, 0, 5);
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            if (o_valid) seen++;
            @(negedge i_clk);
        end
        check("mulu_pulse_no_extra", 70'(seen), 70'd0);

        // Reset at iteration 10 of a divide aborts it with no response.
        i_funct = 5'b01101; i_data1 = 32'd100; i_data2 = 32'd7; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (10) @(posedge i_clk);
        #1 i_rst_n = 1'b0;
        #1;
        check("div_abort_outputs", dut_pack, 70'd0);
        check("div_abort_handshake", 70'({o_valid, o_ready}), 70'b01);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge i_clk);
            if (o_valid) seen++;
        end
        check("div_abort_no_valid", 70'(seen), 70'd0);
        apply("after_abort", 5'b00110, 32'd3, 32'd5, {32'h0, 32'hFFFFFFFE, 5'b01000}, 1, 0, -1);

        // Randomized operations against the reference model.
        for (int n = 0; n < 150; n++) begin
            f = ops[$urandom_range(0, 13)];
            a = pick_val();
            b = pick_val();
            apply($sformatf("rand%0d_f%b", n, f), f, a, b, model(f, a, b), model_lat(f, b),
                  $urandom_range(0, 2), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
